shift_rotate_seq: RTL and testbench

Iterative multi-position shift/rotate controller that sits directly upstream of the single-position shift_rotate core. It accepts a command (operand, opcode, amount) over a valid/ready handshake and applies the core's one-position operation once per clock, amount times. It then presents the result downstream over a second valid/ready handshake. It is the sequential front-end that turns the combinational one-step unit into a variable-amount shifter.

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_rotate.sv | 25 ++
 rtl/shift_rotate_seq.sv | 96 +++++++++
 tb/tb_shift_rotate_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate datapath: opcodes, sequencer
// states and the default operand width.
package shift_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [2:0] OP_SHL  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_ROL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_SAR  = 3'b100;
  localparam logic [2:0] OP_PASS = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Opcodes above PASS have no defined operation.
  function automatic logic op_illegal(input logic [2:0] op);
    return op > OP_PASS;
  endfunction

endpackage

// File: rtl/shift_rotate.sv
// Combinational one-position shift/rotate core. Illegal opcodes pass the
// operand through unchanged.
module shift_rotate
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a;
    case (opcode)
      OP_SHL:  y = {a[WIDTH-2:0], 1'b0};
      OP_SHR:  y = {1'b0, a[WIDTH-1:1]};
      OP_ROL:  y = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  y = {a[0], a[WIDTH-1:1]};
      OP_SAR:  y = {a[WIDTH-1], a[WIDTH-1:1]};
      default: y = a;
    endcase
  end

endmodule

// File: rtl/shift_rotate_seq.sv
// Iterative shift/rotate sequencer: accepts a command, applies the one-step
// core once per clock for the requested amount, then offers the result.
module shift_rotate_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_op,
  output logic             out_err,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] step_y;
  logic             in_illegal;

  shift_rotate #(.WIDTH(WIDTH)) u_core (
    .a      (data_q),
    .opcode (op_q),
    .y      (step_y)
  );

  assign in_illegal = op_illegal(in_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = in_data;
          op_d   = in_op;
          cnt_d  = in_amt;
          err_d  = in_illegal;
          // Zero-step and illegal commands skip RUN; illegal data passes through.
          if (in_illegal || (in_amt == '0)) state_d = DONE;
          else                              state_d = RUN;
        end
      end
      RUN: begin
        data_d = step_y;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == AMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Both ports are valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; a producer holds valid and its payload
  // stable until that edge, and ready never depends on the same-cycle valid.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = (state_q == DONE) ? data_q : '0;
  assign out_op    = (state_q == DONE) ? op_q : '0;
  assign out_err   = (state_q == DONE) ? err_q : 1'b0;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Bench for shift_rotate_seq: directed vector table, hand-written handshake
// and reset sequences, and random commands against a reference model.
module tb_shift_rotate_seq;
  import shift_pkg::*;

  localparam int W = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [2:0]   in_op;
  logic [A-1:0] in_amt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   out_op;
  logic         out_err;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [2:0] op;
    logic [2:0] amt;
    int         hold;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[$];

  shift_rotate_seq #(.WIDTH(W), .AMT_W(A)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_op    (out_op),
    .out_err   (out_err),
    .busy      (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: whole-amount operation computed directly with integer arithmetic.
  function automatic logic [W:0] ref_model(input logic [7:0] d, input logic [2:0] op, input int n);
    int unsigned v;
    int          sv;
    int unsigned r;
    v  = d;
    sv = int'($signed(d));
    case (op)
      3'd0:    r = (v << n) & 32'hFF;
      3'd1:    r = v >> n;
      3'd2:    r = ((v << n) | (v >> (8 - n))) & 32'hFF;
      3'd3:    r = ((v >> n) | (v << (8 - n))) & 32'hFF;
      3'd4:    r = int'(sv >>> n) & 32'hFF;
      default: r = v;
    endcase
    return {op > 3'd5, r[7:0]};
  endfunction

  // driver: issue one command, wait for the result, hold it, then accept it
  task automatic do_cmd(input string name, input logic [7:0] d, input logic [2:0] op,
                        input logic [2:0] amt, input int hold,
                        input logic [7:0] exp_d, input logic exp_e);
    int guard;
    int lat;
    int exp_lat;
    exp_lat = (op > 3'd5) ? 0 : int'(amt);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_op = op; in_amt = amt;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check({name, "_accept_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 50) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom); in_op = 3'($urandom); in_amt = 3'($urandom);
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    if (!out_valid) begin
      in_valid = 1'b0;
      return;
    end
    check({name, "_data"}, out_data, exp_d);
    check({name, "_err"}, out_err, exp_e);
    check({name, "_op"}, out_op, op);
    check({name, "_inready_done"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_data"}, out_data, exp_d);
      check({name, "_hold_err"}, out_err, exp_e);
      check({name, "_hold_inready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_post_valid"}, out_valid, 0);
    check({name, "_post_inready"}, in_ready, 1);
  endtask

  initial begin
    logic [W:0] e;
    logic [W:0] got;
    int         guard;
    bit         seen;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0; in_amt = '0; out_ready = 1'b0;
    #12;
    check("rst_inready", in_ready, 1);
    check("rst_outvalid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_outdata", out_data, 0);
    check("rst_outerr", out_err, 0);
    check("rst_outop", out_op, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed vector table
    vecs.push_back('{"rol3",  8'b10110101, OP_ROL,  3'd3, 0, 8'b10101101, 1'b0});
    vecs.push_back('{"sar3",  8'b10110101, OP_SAR,  3'd3, 0, 8'b11110110, 1'b0});
    vecs.push_back('{"shl2bp",8'b10110101, OP_SHL,  3'd2, 5, 8'b11010100, 1'b0});
    vecs.push_back('{"ror0",  8'b10110101, OP_ROR,  3'd0, 1, 8'b10110101, 1'b0});
    vecs.push_back('{"ill7",  8'b10110101, 3'b111,  3'd5, 2, 8'b10110101, 1'b1});
    vecs.push_back('{"ill6",  8'b01001110, 3'b110,  3'd0, 0, 8'b01001110, 1'b1});
    vecs.push_back('{"shl7",  8'b10110101, OP_SHL,  3'd7, 0, 8'b10000000, 1'b0});
    vecs.push_back('{"shr7",  8'b10110101, OP_SHR,  3'd7, 0, 8'b00000001, 1'b0});
    vecs.push_back('{"sar7",  8'b10110101, OP_SAR,  3'd7, 0, 8'b11111111, 1'b0});
    vecs.push_back('{"rol7",  8'b10110101, OP_ROL,  3'd7, 0, 8'b11011010, 1'b0});
    vecs.push_back('{"pass4", 8'b10110101, OP_PASS, 3'd4, 0, 8'b10110101, 1'b0});
    for (int i = 0; i < vecs.size(); i++)
      do_cmd(vecs[i].name, vecs[i].data, vecs[i].op, vecs[i].amt, vecs[i].hold,
             vecs[i].exp_data, vecs[i].exp_err);

    // back-to-back: second command held valid while the first is in flight
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'b10110101; in_op = OP_SHR; in_amt = 3'd4;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'b10110101; in_op = OP_ROR; in_amt = 3'd1;
    guard = 0;
    while (!out_valid && guard < 50) begin
      check("b2b_inready_busy", in_ready, 0);
      @(negedge clk);
      guard++;
    end
    check("b2b_first_lat", guard, 4);
    check("b2b_first_data", out_data, 8'b00001011);
    check("b2b_first_op", out_op, OP_SHR);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle_inready", in_ready, 1);
    check("b2b_idle_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("b2b_second_lat", guard, 1);
    check("b2b_second_data", out_data, 8'b11011010);
    check("b2b_second_op", out_op, OP_ROR);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // reset in the middle of RUN
    in_valid = 1'b1; in_data = 8'b10110101; in_op = OP_SHL; in_amt = 3'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_valid", out_valid, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_inready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mid_no_result", seen, 0);
    check("mid_after_inready", in_ready, 1);
    do_cmd("after_rst", 8'b01100011, OP_ROL, 3'd2, 1, 8'b10001101, 1'b0);

    // random commands against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [7:0] d;
      logic [2:0] op;
      logic [2:0] amt;
      d   = 8'($urandom);
      op  = 3'($urandom_range(0, 7));
      amt = 3'($urandom_range(0, 7));
      exp_q.push_back(ref_model(d, op, int'(amt)));
      e = exp_q.pop_front();
      do_cmd("rand", d, op, amt, $urandom_range(0, 3), e[7:0], e[8]);
    end

    got = '0;
    check("queue_empty", exp_q.size(), 0);
    check("final_idle", {busy, in_ready, got[0]}, 3'b010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
